mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the unified instruction/data memory of the multicycle ARM core. The processor datapath (CPU port) and a program loader/DMA port (DMA port) share the single memory through it. The arbiter grants one owner at a time with round-robin fairness and a bounded hold time, and drives the memory address, write-data and write-enable lines from the current owner. It sits between `top`'s datapath and the memory, replacing the direct datapath-to-memory connection.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `MAX_HOLD`, default 8: maximum consecutive granted cycles per owner while the other port is requesting. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `c_req`  in  1  CPU requests memory.
- `c_we`  in  1  CPU write strobe.
- `c_adr`  in  AW  CPU address.
- `c_wdata`  in  DW  CPU write data.
- `c_gnt`  out  1  CPU owns memory.
- `d_req`, `d_we`, `d_adr`, `d_wdata`  in  1/1/AW/DW  DMA equivalents.
- `d_gnt`  out  1  DMA owns memory.
- `mem_adr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  DW  memory read data (combinational read).
- `rdata`  out  DW  `mem_rdata` broadcast to both ports.
- `stall_cnt`  out  16  contention counter (see Configuration).

## Operation
- FSM states: `IDLE`, `CPU`, `DMA`. `c_gnt` = (state==CPU); `d_gnt` = (state==DMA). Both grants are registered and never high together.
- `last_owner` register resets to DMA, so the CPU wins the first tie.
- From `IDLE`:
  - only `c_req` → `CPU`;
  - only `d_req` → `DMA`;
  - both → the port that is not `last_owner`;
  - neither → stay.
- From `CPU` (`DMA` symmetric):
  - `c_req`=0 → `DMA` if `d_req`, else `IDLE`;
  - `c_req`=1, `d_req`=1, `hold_cnt`==MAX_HOLD-1 → `DMA` (preempt);
  - otherwise stay.
- `last_owner` updates to the current owner on every edge that leaves an owner state.
- `hold_cnt`: `clog2(MAX_HOLD)+1` bits. Cleared on entering any owner state and in `IDLE`. Increments each cycle in an owner state and saturates at MAX_HOLD-1. It only triggers a switch if the other port is requesting, so a lone requester holds the memory indefinitely.
- A transfer happens in a cycle where the owner's req=1 and gnt=1. In that cycle:
  - `mem_adr` and `mem_wdata` come from the owner;
  - `mem_we` = owner req & owner we.
- No transfer: `mem_we`=0, `mem_adr`=0, `mem_wdata`=0. This covers `IDLE` and any cycle where the owner has req=0.
- A requester must hold req, we, adr and wdata stable until it sees its gnt. Data is read from `rdata` in the same cycle as a granted read.

## Timing
- Reset values: state `IDLE`, `c_gnt`=0, `d_gnt`=0, `mem_we`=0, `mem_adr`=0, `mem_wdata`=0, `hold_cnt`=0, `last_owner`=DMA, `stall_cnt`=0.
- Grant latency: req rising in cycle t from `IDLE` → gnt high in cycle t+1.
- Release: owner drops req in cycle t → gnt low in t+1. Cycle t carries no transfer.
- Handover, preempt or release with the other port waiting: old gnt low and new gnt high on the same edge, with no idle cycle between owners.
- Preemption: the owner receives exactly MAX_HOLD granted cycles. The last of them still performs its transfer.
- Reset asserted mid-transfer: at that edge both grants drop and `mem_we`=0 the following cycle. A write in progress in the reset cycle itself still completes, since it is combinational from inputs.
- `mem_we`, `mem_adr` and `mem_wdata` are combinational from the registered state and port inputs. There are no extra register stages.

## Configuration
- `ARB_STATS_EN` defined: `stall_cnt` increments on each cycle where one port owns the memory and the other has req=1 and gnt=0. It saturates at 16'hFFFF and is cleared by reset.
- `ARB_STATS_EN` undefined: no counter logic is built and `stall_cnt` is tied to 16'h0000.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with both reqs high. During reset and in the first cycle after it, `c_gnt`=`d_gnt`=0, `mem_we`=0, `mem_adr`=0.
- Single CPU write: `c_req`=1, `c_we`=1, `c_adr`=92, `c_wdata`=7 in cycle 0. Cycle 1 gives `c_gnt`=1, `mem_we`=1, `mem_adr`=92, `mem_wdata`=7.
- Tie after reset: both req rise in cycle 0. CPU is granted in cycle 1. CPU drops req in cycle 2, so `d_gnt`=1 in cycle 3.
- Preemption, MAX_HOLD=4: CPU req held from cycle 0 and DMA req from cycle 1. `c_gnt` is high in cycles 1–4 and `d_gnt` is high from cycle 5. With `ARB_STATS_EN`, `stall_cnt`=4 in cycle 5.
- Lone owner: only `d_req`, held for 20 cycles with MAX_HOLD=4. `d_gnt` stays high continuously. After `d_req` drops in cycle t, `d_gnt`=0 and `mem_we`=0 in cycle t+1.
- Reset mid-transfer: DMA owns and writes `d_adr`=0x40, then `reset` pulses for one cycle. Both grants are 0 the next cycle. After release with only `c_req` high, the CPU is granted one cycle later.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared instruction/data memory (CPU vs. DMA/loader).
// Define ARB_STATS_EN to build the saturating contention counter behind stall_cnt.
module mem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD) + 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("mem_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCpu,
    StDma
  } state_e;

  state_e           state_q, state_d;
  logic             last_dma_q;  // 1: DMA was the last owner, so CPU wins the next tie
  logic [HoldW-1:0] hold_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (c_req && d_req) begin
          state_d = last_dma_q ? StCpu : StDma;
        end else if (c_req) begin
          state_d = StCpu;
        end else if (d_req) begin
          state_d = StDma;
        end
      end
      StCpu: begin
        if (!c_req) begin
          state_d = d_req ? StDma : StIdle;
        end else if (d_req && (hold_q == HoldMax)) begin
          state_d = StDma;
        end
      end
      StDma: begin
        if (!d_req) begin
          state_d = c_req ? StCpu : StIdle;
        end else if (c_req && (hold_q == HoldMax)) begin
          state_d = StCpu;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grants are registered copies of the next state so they change only on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      c_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      last_dma_q <= 1'b1;
      hold_q     <= '0;
    end else begin
      state_q <= state_d;
      c_gnt   <= (state_d == StCpu);
      d_gnt   <= (state_d == StDma);
      if ((state_q != StIdle) && (state_d != state_q)) begin
        last_dma_q <= (state_q == StDma);
      end
      if ((state_d == StIdle) || (state_d != state_q)) begin
        hold_q <= '0;
      end else if (hold_q != HoldMax) begin
        hold_q <= hold_q + HoldW'(1);
      end
    end
  end

  logic cpu_xfer, dma_xfer;
  assign cpu_xfer = c_gnt & c_req;
  assign dma_xfer = d_gnt & d_req;

  // Memory side is combinational from the registered grant and the live port inputs.
  always_comb begin
    mem_adr   = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_xfer) begin
      mem_adr   = c_adr;
      mem_wdata = c_wdata;
      mem_we    = c_we;
    end else if (dma_xfer) begin
      mem_adr   = d_adr;
      mem_wdata = d_wdata;
      mem_we    = d_we;
    end
  end

  assign rdata = mem_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] stall_q;
  logic        contended;

  assign contended = (c_gnt & d_req & ~d_gnt) | (d_gnt & c_req & ~c_gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (contended && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vectors through a scoreboard queue.
module tb_mem_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned MaxHold = 4;
`ifdef ARB_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic          clk, reset;
  logic          c_req, c_we, c_gnt, d_req, d_we, d_gnt, mem_we;
  logic [AW-1:0] c_adr, d_adr, mem_adr;
  logic [DW-1:0] c_wdata, d_wdata, mem_wdata, mem_rdata, rdata;
  logic [15:0]   stall_cnt;

  mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_adr    (c_adr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_adr    (d_adr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .rdata    (rdata),
    .stall_cnt(stall_cnt)
  );

  // Simple combinational memory: read data is a fixed function of the address.
  assign mem_rdata = mem_adr ^ 32'h5A5A_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        ecg, edg, ewe;
    logic [31:0] eadr, ewd;
    logic        cs;
    logic [15:0] es;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(int rst, int cr, int cw, int ca, int cd, int dr, int dw, int da,
                              int dd, int ecg, int edg, int ewe, int eadr, int ewd);
    vec_t v;
    v.rst = (rst != 0);
    v.cr = (cr != 0);   v.cw = (cw != 0);   v.ca = ca;     v.cd = cd;
    v.dr = (dr != 0);   v.dw = (dw != 0);   v.da = da;     v.dd = dd;
    v.ecg = (ecg != 0); v.edg = (edg != 0); v.ewe = (ewe != 0);
    v.eadr = eadr;      v.ewd = ewd;
    v.cs = 1'b0;        v.es = 16'h0;
    return v;
  endfunction

  function automatic vec_t with_stall(vec_t v, int es);
    vec_t r = v;
    r.cs = 1'b1;
    r.es = 16'(es);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic run(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    reset = v.rst;
    c_req = v.cr; c_we = v.cw; c_adr = v.ca; c_wdata = v.cd;
    d_req = v.dr; d_we = v.dw; d_adr = v.da; d_wdata = v.dd;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("c_gnt", {31'b0, c_gnt}, {31'b0, e.ecg});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, e.edg});
    chk("mem_we", {31'b0, mem_we}, {31'b0, e.ewe});
    chk("mem_adr", mem_adr, e.eadr);
    chk("mem_wdata", mem_wdata, e.ewd);
    chk("rdata", rdata, e.eadr ^ 32'h5A5A_0000);
    if (e.cs) chk("stall_cnt", {16'h0, stall_cnt}, {16'h0, e.es});
  endtask

  initial begin
    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0;
    @(posedge clk);

    // Reset with both requesting, then tie (CPU wins), single CPU write, handover to DMA.
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 92, 7, 1, 1, 'h20, 'h55, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 92, 7, 1, 1, 'h20, 'h55, 1, 0, 1, 92, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h20, 'h55, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h20, 'h55, 0, 1, 1, 'h20, 'h55));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // CPU read: grant one cycle after request, release leaves a no-transfer cycle.
    tbl.push_back(mk(0, 1, 0, 'h30, 'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h30, 'h11, 0, 0, 0, 0, 1, 0, 0, 'h30, 'h11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Fresh reset, then preemption after MaxHold cycles each way.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(with_stall(mk(0, 1, 1, 'h100, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 1, 'h100, 'hAA, 1, 1, 'h200, 'hBB, 1, 0, 1, 'h100, 'hAA));
    tbl.push_back(with_stall(mk(0, 1, 1, 'h100, 'hAA, 1, 1, 'h200, 'hBB, 0, 1, 1, 'h200, 'hBB),
                             StatsEn ? 4 : 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 1, 'h100, 'hAA, 1, 1, 'h200, 'hBB, 0, 1, 1, 'h200, 'hBB));
    tbl.push_back(mk(0, 1, 1, 'h100, 'hAA, 1, 1, 'h200, 'hBB, 1, 0, 1, 'h100, 'hAA));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Lone DMA requester holds for 20 cycles without preemption.
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h300, 'hCC, 0, 0, 0, 0, 0));
    for (int i = 0; i < 19; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h300, 'hCC, 0, 1, 1, 'h300, 'hCC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset pulse while DMA is writing: the reset-cycle write still lands, grants drop after.
    run(mk(0, 0, 0, 0, 0, 1, 1, 'h40, 'hDD, 0, 0, 0, 0, 0));
    run(mk(0, 0, 0, 0, 0, 1, 1, 'h40, 'hDD, 0, 1, 1, 'h40, 'hDD));
    run(mk(1, 0, 0, 0, 0, 1, 1, 'h40, 'hDD, 0, 1, 1, 'h40, 'hDD));
    run(mk(0, 1, 0, 'h50, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run(mk(0, 1, 0, 'h50, 'h22, 0, 0, 0, 0, 1, 0, 0, 'h50, 'h22));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // CPU was last owner, so a tie from idle now goes to DMA.
    run(mk(0, 1, 1, 'h60, 'h33, 1, 0, 'h70, 'h44, 0, 0, 0, 0, 0));
    run(mk(0, 1, 1, 'h60, 'h33, 1, 0, 'h70, 'h44, 0, 1, 0, 'h70, 'h44));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
